// File: rtl/iram_access_seq.sv
// Sequencer in front of the 8051 internal data RAM. It turns one CPU request into DATARAM
// chip-select cycles, resolves bank, bit and @Ri addresses, owns SP and returns one response.
module iram_access_seq #(
    parameter logic [7:0] SP_RESET = 8'h07,
    parameter logic [7:0] IRAM_TOP = 8'h7F
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [2:0] req_op,
    input  logic [7:0] req_addr,
    input  logic [7:0] req_data,
    input  logic       req_bit,
    input  logic [1:0] rs,
    output logic       rsp_valid,
    output logic [7:0] rsp_data,
    output logic       rsp_bit,
    output logic       rsp_err,
    output logic [7:0] sp,
    output logic       ram_cs,
    output logic       ram_rw,
    output logic       ram_bb,
    output logic [7:0] ram_addr,
    output logic [7:0] ram_pos,
    output logic [7:0] ram_din,
    output logic       ram_bin,
    input  logic [7:0] ram_dout,
    input  logic       ram_bout
);

    typedef enum logic [2:0] {IDLE, PTR, PCAP, ACC, CAP, RESP} state_t;
    typedef enum logic [2:0] {
        OP_RDD = 3'b000, OP_WRD = 3'b001, OP_RDI = 3'b010, OP_WRI = 3'b011,
        OP_RDB = 3'b100, OP_WRB = 3'b101, OP_PUSH = 3'b110, OP_POP = 3'b111
    } op_t;

    state_t     state_q, state_d;
    op_t        op_q, op_d;
    logic [7:0] addr_q, addr_d;
    logic [7:0] data_q, data_d;
    logic       bit_q, bit_d;
    logic [1:0] rs_q, rs_d;
    logic [7:0] ptr_q, ptr_d;
    logic       err_q, err_d;
    logic [7:0] sp_q, sp_d;
    logic [7:0] rsp_data_q, rsp_data_d;
    logic       rsp_bit_q, rsp_bit_d;

    function automatic logic op_is_read(input op_t op);
        return op inside {OP_RDD, OP_RDI, OP_RDB, OP_POP};
    endfunction

    // Out-of-range conditions that are already known when the request is accepted.
    function automatic logic accept_err(input op_t op, input logic [7:0] a, input logic [7:0] s);
        logic e;
        e = 1'b0;
        case (op)
            OP_RDD, OP_WRD: e = (a > IRAM_TOP);
            OP_RDB, OP_WRB: e = a[7];
            OP_PUSH:        e = ((s + 8'd1) > IRAM_TOP);
            OP_POP:         e = (s > IRAM_TOP);
            default:        e = 1'b0;
        endcase
        return e;
    endfunction

    // NOTE: non-blocking assignments on every flop so all state updates on an edge see the same old values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            op_q       <= OP_RDD;
            addr_q     <= 8'h00;
            data_q     <= 8'h00;
            bit_q      <= 1'b0;
            rs_q       <= 2'b00;
            ptr_q      <= 8'h00;
            err_q      <= 1'b0;
            sp_q       <= SP_RESET;
            rsp_data_q <= 8'h00;
            rsp_bit_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            bit_q      <= bit_d;
            rs_q       <= rs_d;
            ptr_q      <= ptr_d;
            err_q      <= err_d;
            sp_q       <= sp_d;
            rsp_data_q <= rsp_data_d;
            rsp_bit_q  <= rsp_bit_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (req_valid)
                      state_d = (op_t'(req_op) inside {OP_RDI, OP_WRI}) ? PTR : ACC;
            PTR:  state_d = PCAP;
            PCAP: state_d = ACC;
            ACC:  state_d = (op_is_read(op_q) && !err_q) ? CAP : RESP;
            CAP:  state_d = RESP;
            RESP: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: every variable gets a default before the case so no path infers a latch.
    always_comb begin
        op_d       = op_q;
        addr_d     = addr_q;
        data_d     = data_q;
        bit_d      = bit_q;
        rs_d       = rs_q;
        ptr_d      = ptr_q;
        err_d      = err_q;
        sp_d       = sp_q;
        rsp_data_d = rsp_data_q;
        rsp_bit_d  = rsp_bit_q;
        case (state_q)
            IDLE: if (req_valid) begin
                op_d   = op_t'(req_op);
                addr_d = req_addr;
                data_d = req_data;
                bit_d  = req_bit;
                rs_d   = rs;
                err_d  = accept_err(op_t'(req_op), req_addr, sp_q);
            end
            PCAP: begin
                ptr_d = ram_dout;
                err_d = (ram_dout > IRAM_TOP);
            end
            ACC: begin
                // SP moves even when the stack access itself was suppressed as out of range.
                if (op_q == OP_PUSH) sp_d = sp_q + 8'd1;
                if (op_q == OP_POP)  sp_d = sp_q - 8'd1;
            end
            CAP: begin
                if (op_q == OP_RDB) rsp_bit_d  = ram_bout;
                else                rsp_data_d = ram_dout;
            end
            default: ;
        endcase
    end

    always_comb begin
        req_ready = (state_q == IDLE);
        rsp_valid = (state_q == RESP);
        rsp_err   = (state_q == RESP) && err_q;
        ram_cs    = 1'b1;
        ram_rw    = 1'b1;
        ram_bb    = 1'b1;
        ram_addr  = 8'h00;
        ram_pos   = 8'h00;
        ram_din   = 8'h00;
        ram_bin   = 1'b0;
        if (state_q == PTR) begin
            ram_cs   = 1'b0;
            ram_addr = {3'b000, rs_q, 2'b00, addr_q[0]};
        end else if (state_q == ACC && !err_q) begin
            ram_cs = 1'b0;
            ram_rw = op_is_read(op_q);
            case (op_q)
                OP_RDD, OP_WRD: ram_addr = addr_q;
                OP_RDI, OP_WRI: ram_addr = ptr_q;
                OP_RDB, OP_WRB: begin
                    ram_bb   = 1'b0;
                    ram_addr = 8'h20 + {4'h0, addr_q[6:3]};
                    ram_pos  = 8'h01 << addr_q[2:0];
                end
                OP_PUSH: ram_addr = sp_q + 8'd1;
                OP_POP:  ram_addr = sp_q;
                default: ;
            endcase
            if (op_q inside {OP_WRD, OP_WRI, OP_PUSH}) ram_din = data_q;
            if (op_q == OP_WRB)                         ram_bin = bit_q;
        end
    end

    assign rsp_data = rsp_data_q;
    assign rsp_bit  = rsp_bit_q;
    assign sp       = sp_q;

endmodule

// File: tb/tb_iram_access_seq.sv
// Bench for iram_access_seq: a behavioural DATARAM, directed scenarios and random requests,
// all compared against a request-level reference model of memory, SP, latency and RAM cycles.
module tb_iram_access_seq;

    logic       clk = 1'b0;
    logic       reset;
    logic       req_valid, req_ready;
    logic [2:0] req_op;
    logic [7:0] req_addr, req_data;
    logic       req_bit;
    logic [1:0] rs;
    logic       rsp_valid, rsp_bit, rsp_err;
    logic [7:0] rsp_data, sp;
    logic       ram_cs, ram_rw, ram_bb, ram_bin;
    logic [7:0] ram_addr, ram_pos, ram_din;
    logic [7:0] ram_dout = 8'h00;
    logic       ram_bout = 1'b0;

    int errors = 0;
    int checks = 0;

    iram_access_seq dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_addr(req_addr),
        .req_data(req_data), .req_bit(req_bit), .rs(rs),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_bit(rsp_bit), .rsp_err(rsp_err), .sp(sp),
        .ram_cs(ram_cs), .ram_rw(ram_rw), .ram_bb(ram_bb), .ram_addr(ram_addr), .ram_pos(ram_pos),
        .ram_din(ram_din), .ram_bin(ram_bin), .ram_dout(ram_dout), .ram_bout(ram_bout)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Behavioural DATARAM: read data appears the cycle after a read chip select.
    logic [7:0] mem [256] = '{default: 8'h00};
    always @(posedge clk) begin
        if (!ram_cs) begin
            if (!ram_rw) begin
                if (ram_bb) mem[ram_addr] <= ram_din;
                else        mem[ram_addr] <= ram_bin ? (mem[ram_addr] | ram_pos) : (mem[ram_addr] & ~ram_pos);
            end else begin
                ram_dout <= mem[ram_addr];
                ram_bout <= |(mem[ram_addr] & ram_pos);
            end
        end
    end

    // Every chip-select cycle: {rw, bb, addr, pos, din (byte writes), bin (bit writes)}.
    logic [26:0] acc_q [$];
    always @(negedge clk) begin
        if (reset && !ram_cs)
            acc_q.push_back({ram_rw, ram_bb, ram_addr, ram_pos,
                             (!ram_rw && ram_bb) ? ram_din : 8'h00,
                             (!ram_rw && !ram_bb) ? ram_bin : 1'b0});
    end

    function automatic logic [26:0] enc(input logic rw, input logic bb, input logic [7:0] a,
                                        input logic [7:0] pos, input logic [7:0] din, input logic bin);
        return {rw, bb, a, pos, din, bin};
    endfunction

    logic [7:0] ref_mem [256];
    logic [7:0] ref_sp;

    task automatic run_op(input logic [2:0] op, input logic [7:0] addr, input logic [7:0] data,
                          input logic b, input logic [1:0] rsv);
        int          exp_lat, got_lat, base;
        logic        exp_err, exp_bit, chk_data, chk_bit;
        logic [7:0]  exp_data, pa, p, ba, pos, na;
        logic [26:0] exp_acc [$];
        logic [7:0]  got_data;
        logic        got_bit, got_err;
        exp_err = 0; exp_bit = 0; exp_data = 0; chk_data = 0; chk_bit = 0; exp_lat = 2;
        case (op)
            3'b000, 3'b001: begin
                if (addr > 8'h7F) exp_err = 1;
                else if (op == 3'b000) begin
                    exp_acc.push_back(enc(1, 1, addr, 0, 0, 0));
                    exp_data = ref_mem[addr]; chk_data = 1; exp_lat = 3;
                end else begin
                    exp_acc.push_back(enc(0, 1, addr, 0, data, 0));
                    ref_mem[addr] = data;
                end
            end
            3'b010, 3'b011: begin
                pa = 8'(rsv * 8 + addr[0]);
                exp_acc.push_back(enc(1, 1, pa, 0, 0, 0));
                p = ref_mem[pa];
                exp_lat = 4;
                if (p > 8'h7F) exp_err = 1;
                else if (op == 3'b010) begin
                    exp_acc.push_back(enc(1, 1, p, 0, 0, 0));
                    exp_data = ref_mem[p]; chk_data = 1; exp_lat = 5;
                end else begin
                    exp_acc.push_back(enc(0, 1, p, 0, data, 0));
                    ref_mem[p] = data;
                end
            end
            3'b100, 3'b101: begin
                if (addr >= 8'h80) exp_err = 1;
                else begin
                    ba  = 8'h20 + addr / 8;
                    pos = 8'(1 << (addr % 8));
                    if (op == 3'b100) begin
                        exp_acc.push_back(enc(1, 0, ba, pos, 0, 0));
                        exp_bit = (ref_mem[ba] & pos) != 0; chk_bit = 1; exp_lat = 3;
                    end else begin
                        exp_acc.push_back(enc(0, 0, ba, pos, 0, b));
                        ref_mem[ba] = b ? (ref_mem[ba] | pos) : (ref_mem[ba] & ~pos);
                    end
                end
            end
            3'b110: begin
                na = ref_sp + 8'd1;
                ref_sp = na;
                if (na > 8'h7F) exp_err = 1;
                else begin
                    exp_acc.push_back(enc(0, 1, na, 0, data, 0));
                    ref_mem[na] = data;
                end
            end
            default: begin
                if (ref_sp > 8'h7F) exp_err = 1;
                else begin
                    exp_acc.push_back(enc(1, 1, ref_sp, 0, 0, 0));
                    exp_data = ref_mem[ref_sp]; chk_data = 1; exp_lat = 3;
                end
                ref_sp = ref_sp - 8'd1;
            end
        endcase

        @(negedge clk);
        check("req_ready_idle", req_ready, 1);
        base = acc_q.size();
        req_valid = 1; req_op = op; req_addr = addr; req_data = data; req_bit = b; rs = rsv;
        @(posedge clk);
        got_lat = 0; got_data = 0; got_bit = 0; got_err = 0;
        for (int cyc = 1; cyc <= 12 && got_lat == 0; cyc++) begin
            @(negedge clk);
            if (cyc == 1) check("req_ready_busy", req_ready, 0);
            if (rsp_valid) begin
                got_lat = cyc; got_data = rsp_data; got_bit = rsp_bit; got_err = rsp_err;
                req_valid = 0;
            end else begin
                // Busy-time noise on the request port, including rs, must have no effect.
                req_valid = 1'($urandom_range(1, 0));
                req_op    = 3'($urandom_range(7, 0));
                req_addr  = 8'($urandom_range(255, 0));
                req_data  = 8'($urandom_range(255, 0));
                req_bit   = 1'($urandom_range(1, 0));
                rs        = 2'($urandom_range(3, 0));
            end
        end
        req_valid = 0;
        if (got_lat == 0) check("rsp_timeout", 0, 1);
        else begin
            check("latency", got_lat, exp_lat);
            check("rsp_err", got_err, exp_err);
            if (chk_data) check("rsp_data", got_data, exp_data);
            if (chk_bit)  check("rsp_bit", got_bit, exp_bit);
            check("sp", sp, ref_sp);
            check("acc_count", acc_q.size() - base, exp_acc.size());
            for (int i = 0; i < exp_acc.size() && base + i < acc_q.size(); i++)
                check("acc_cycle", acc_q[base + i], exp_acc[i]);
            @(negedge clk);
            check("rsp_one_cycle", rsp_valid, 0);
        end
    endtask

    task automatic check_reset_state();
        check("rst_sp", sp, 8'h07);
        check("rst_ram_cs", ram_cs, 1);
        check("rst_ram_rw", ram_rw, 1);
        check("rst_ram_bb", ram_bb, 1);
        check("rst_ram_addr", ram_addr, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_data", rsp_data, 0);
        check("rst_rsp_err", rsp_err, 0);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) ref_mem[i] = 8'h00;
        ref_sp = 8'h07;
        reset = 0; req_valid = 0; req_op = 0; req_addr = 0; req_data = 0; req_bit = 0; rs = 0;
        repeat (3) @(negedge clk);
        check_reset_state();
        reset = 1;
        @(negedge clk);

        run_op(3'b001, 8'h30, 8'h5A, 0, 0);
        run_op(3'b000, 8'h30, 8'h00, 0, 0);
        check("rdd_30", rsp_data, 8'h5A);

        run_op(3'b001, 8'h11, 8'h45, 0, 0);
        run_op(3'b001, 8'h45, 8'hC3, 0, 0);
        run_op(3'b010, 8'h01, 8'h00, 0, 2'b10);
        run_op(3'b011, 8'h01, 8'h3C, 0, 2'b10);

        run_op(3'b101, 8'h2B, 8'h00, 1, 0);
        run_op(3'b100, 8'h2B, 8'h00, 0, 0);
        run_op(3'b000, 8'h25, 8'h00, 0, 0);
        run_op(3'b101, 8'h7F, 8'h00, 1, 0);
        run_op(3'b100, 8'h7F, 8'h00, 0, 0);

        run_op(3'b110, 8'h00, 8'hAA, 0, 0);
        run_op(3'b111, 8'h00, 8'h00, 0, 0);

        // Pointer fetch of a value above the RAM top.
        run_op(3'b001, 8'h09, 8'h90, 0, 0);
        run_op(3'b010, 8'h01, 8'h00, 0, 2'b01);
        run_op(3'b011, 8'h01, 8'h12, 0, 2'b01);

        while (ref_sp != 8'h7F) run_op(3'b110, 8'h00, 8'($urandom_range(255, 0)), 0, 0);
        run_op(3'b110, 8'h00, 8'h55, 0, 0);
        run_op(3'b111, 8'h00, 8'h00, 0, 0);
        run_op(3'b111, 8'h00, 8'h00, 0, 0);
        run_op(3'b100, 8'h90, 8'h00, 0, 0);
        run_op(3'b000, 8'hA0, 8'h00, 0, 0);
        run_op(3'b001, 8'h80, 8'h11, 0, 0);
        run_op(3'b101, 8'h80, 8'h00, 1, 0);

        // Reset during the ACC cycle of WRD 0x40 <= 0x77.
        run_op(3'b001, 8'h40, 8'h00, 0, 0);
        @(negedge clk);
        req_valid = 1; req_op = 3'b001; req_addr = 8'h40; req_data = 8'h77; req_bit = 0; rs = 0;
        @(posedge clk);
        #1;
        req_valid = 0;
        check("cs_in_acc", ram_cs, 0);
        reset = 0;
        #1;
        check("cs_on_reset", ram_cs, 1);
        repeat (2) begin
            @(negedge clk);
            check("no_rsp_in_reset", rsp_valid, 0);
        end
        ref_sp = 8'h07;
        check_reset_state();
        reset = 1;
        run_op(3'b000, 8'h40, 8'h00, 0, 0);

        for (int n = 0; n < 300; n++) begin
            logic [7:0] a;
            a = ($urandom_range(3, 0) == 0) ? 8'($urandom_range(255, 0)) : 8'($urandom_range(127, 0));
            run_op(3'($urandom_range(7, 0)), a, 8'($urandom_range(255, 0)),
                   1'($urandom_range(1, 0)), 2'($urandom_range(3, 0)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
